// File: rtl/i2c_target_regs.sv
// I2C target with an auto-incrementing register bank of 2**AW bytes.
// The bus side is an open-drain SDA driver; the local side has a registered read port and a write strobe.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         AW          = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_o,
    output logic          sda_oen_o,
    input  logic [AW-1:0] reg_addr_i,
    output logic [7:0]    reg_rdata_o,
    output logic          wr_stb_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [7:0]    wr_data_o,
    output logic          busy_o
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t        state;
    logic [1:0]    scl_sync, sda_sync;
    logic          scl_p, sda_p, scl_f, sda_f, scl_d, sda_d;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [AW-1:0] ptr;
    logic          rw;
    logic [7:0]    bank [DEPTH];

    // Sync flops idle high so releasing reset on an idle bus creates no false START/STOP.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_p    <= scl_sync[1];
            sda_p    <= sda_sync[1];
            if (scl_sync[1] == scl_p) scl_f <= scl_sync[1];
            if (sda_sync[1] == sda_p) sda_f <= sda_sync[1];
            scl_d    <= scl_f;
            sda_d    <= sda_f;
        end
    end

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte, cur;

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    assign rx_byte   = {shreg[6:0], sda_f};
    assign cur       = bank[ptr];
    assign sda_o     = 1'b0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            sda_oen_o <= 1'b0;
            busy_o    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else begin
            wr_stb_o <= 1'b0;
            if (stop_det) begin
                state     <= IDLE;
                sda_oen_o <= 1'b0;
                busy_o    <= 1'b0;
            end else if (start_det) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                sda_oen_o <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                case (state)
                    ADDR, PTR, WDATA: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (rx_byte[7:1] == TARGET_ADDR && rx_byte[7:1] != 7'h00) begin
                                    state  <= ADDR_ACK;
                                    rw     <= rx_byte[0];
                                    busy_o <= 1'b1;
                                end else begin
                                    state  <= IGNORE;
                                    busy_o <= 1'b0;
                                end
                            end else if (state == PTR) begin
                                ptr   <= rx_byte[AW-1:0];
                                state <= PTR_ACK;
                            end else begin
                                bank[ptr] <= rx_byte;
                                wr_stb_o  <= 1'b1;
                                wr_addr_o <= ptr;
                                wr_data_o <= rx_byte;
                                ptr       <= ptr + PTR_ONE;
                                state     <= WDATA_ACK;
                            end
                        end
                    end
                    // First SCL fall after the byte pulls SDA low; the next one releases it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oen_o) begin
                            sda_oen_o <= 1'b1;
                        end else begin
                            sda_oen_o <= 1'b0;
                            bit_cnt   <= '0;
                            if (state == ADDR_ACK && rw) begin
                                state     <= RDATA;
                                shreg     <= {cur[6:0], 1'b0};
                                sda_oen_o <= ~cur[7];
                            end else if (state == ADDR_ACK) begin
                                state <= PTR;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oen_o <= 1'b0;
                            state     <= RDATA_ACK;
                        end else begin
                            sda_oen_o <= ~shreg[7];
                            shreg     <= {shreg[6:0], 1'b0};
                        end
                    end
                    RDATA_ACK: if (scl_rise) begin
                        ptr <= ptr + PTR_ONE;
                        if (sda_f) begin
                            state  <= IGNORE;
                            busy_o <= 1'b0;
                        end
                    end else if (scl_fall) begin
                        state     <= RDATA;
                        bit_cnt   <= '0;
                        shreg     <= {cur[6:0], 1'b0};
                        sda_oen_o <= ~cur[7];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) reg_rdata_o <= '0;
        else         reg_rdata_o <= bank[reg_addr_i];
    end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) with a 2**AW-byte register bank, the bus-side counterpart of the CF_I2C_WB master. It connects to the same open-drain SCL/SDA pad pair in user_project (io_in[8] = SCL, io_in[9] = SDA). It decodes 7-bit addressed transfers, sets an auto-incrementing register pointer, and services reads and writes of the bank. The local side gets a registered read port and a write-notification strobe.

## Interface
- TARGET_ADDR, 7'h50: 7-bit bus address this block responds to.
- AW, 4: register pointer width; bank depth is 2**AW bytes.
- clk_i  in  1  system clock (wb_clk_i at top level); must be ≥ 10× SCL frequency.
- rst_ni  in  1  reset, synchronous and active-low; one clock, synchronous, active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_o  out  1  SDA output value; constant 0.
- sda_oen_o  out  1  SDA output enable, active-high; 1 = pull SDA low. Top level drives io_oeb = ~sda_oen_o.
- reg_addr_i  in  AW  local read address.
- reg_rdata_o  out  8  bank[reg_addr_i], registered.
- wr_stb_o  out  1  one-cycle pulse per byte written from the bus.
- wr_addr_o  out  AW  register index for wr_stb_o.
- wr_data_o  out  8  data byte for wr_stb_o.
- busy_o  out  1  high from an address-matched START until STOP, or until a START/mismatch ends the transfer.

## Operation
- **Input conditioning:** scl_i and sda_i each pass through a 2-FF synchronizer plus a 2-sample agreement filter. All edge and START/STOP detection uses the filtered signals.
- **START:** filtered SDA falls while SCL is high. Valid in any state, including mid-byte (repeated START). Goes to ADDR, clears the bit counter, releases SDA.
- **STOP:** filtered SDA rises while SCL is high. Goes to IDLE from any state; releases SDA; busy_o = 0.
- **Bit timing:** SDA is sampled on SCL rising edges, MSB first. SDA drive changes only on SCL falling edges.
- **State machine:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - **ADDR:** shift 8 bits. If the upper 7 bits equal TARGET_ADDR, go to ADDR_ACK and drive ACK (sda_oen_o = 1) for the 9th clock. Otherwise go to IGNORE, where the block never drives until START or STOP. General call (7'h00) is ignored.
  - **After ADDR_ACK:** R/W = 0 → PTR; R/W = 1 → RDATA, loading the shift register from bank[ptr] on the ACK-clock falling edge.
  - **PTR:** the received byte sets ptr to byte[AW-1:0]; upper bits are ignored. ACK, then WDATA.
  - **WDATA:** each received byte is written to bank[ptr] and ACKed. wr_stb_o pulses with the address/data; then ptr = ptr+1 mod 2**AW (15 wraps to 0 for AW = 4).
  - **RDATA:** drive sda_oen_o = ~bit for 8 bits; release for the 9th clock. On the 9th SCL rise, sample the master's ACK:
    - ACK (SDA = 0): ptr++, reload from the new ptr, stay in RDATA.
    - NACK (SDA = 1): ptr++, go to IGNORE, SDA released.
- **Bank:** resets to 0x00. Local read is read-first: a bus write and a local read of the same index in the same cycle return the old value that cycle.
- **Pointer:** ptr persists across transfers, so a write-PTR then repeated-START read works. Reset clears ptr to 0.
- **Unsupported:** no clock stretching; SCL is never driven.

## Timing
- **Reset values:** every output is 0 (sda_o, sda_oen_o, reg_rdata_o, wr_stb_o, wr_addr_o, wr_data_o, busy_o); state = IDLE; ptr = 0.
- **Reset mid-transfer:** sda_oen_o = 0 on the first clock edge with rst_ni low, whatever the bus is doing.
- **Pad to detection:** 4 clk_i from a pad edge to the detected event (2 sync + 2 filter).
- **SDA drive:** sda_oen_o changes 1 clk after a detected SCL falling edge, i.e. ≤ 5 clk after the pad edge. This stays within the SCL low period given the ≥ 10× clock ratio.
- **Write strobe:** wr_stb_o asserts 1 clk after the detected 8th-bit SCL rise of a WDATA byte, for exactly one cycle. It fires even if a STOP follows immediately.
- **Local read:** reg_rdata_o = bank[reg_addr_i] 1 clk after reg_addr_i is presented.
- **busy_o:** asserts with the ADDR_ACK decision; deasserts 1 clk after STOP/START detection or entry to IGNORE.
- **Glitch rejection:** one-clk glitches on SCL or SDA are rejected.

## Test plan
- **Write burst:** START, 0xA0 (0x50 write), 0x03, 0x11, 0x22, STOP.
  - All four bytes are ACKed.
  - wr_stb_o pulses twice: (3, 0x11), then (4, 0x22).
  - reg_rdata_o at index 4 reads 0x22.
- **Combined read:** START 0xA0, 0x03, repeated START 0xA1, read 2 bytes with ACK then NACK, STOP.
  - Master receives 0x11, 0x22.
  - sda_oen_o = 0 after the NACK; ptr = 5.
- **Address mismatch:** START 0xA2, then 3 bytes, STOP.
  - sda_oen_o stays 0 throughout; no wr_stb_o; busy_o stays 0.
- **Pointer wrap (AW = 4):** write pointer 0x0F, data 0xAA, 0xBB.
  - wr_stb_o at (15, 0xAA), then (0, 0xBB).
  - Read from 0x0F returns 0xAA, 0xBB.
- **Abort mid-byte:** STOP after 4 data bits of WDATA.
  - No wr_stb_o; bank unchanged; state IDLE.
  - A following START 0xA0 is ACKed normally.
- **Reset during ACK:** pull rst_ni low while the block holds SDA low on ADDR_ACK.
  - sda_oen_o = 0 on the next clock edge; all outputs 0.
  - Bank reads 0x00 everywhere.
